can_rx_frame: RTL and testbench
===============================

CAN_RX_FRAME -- requirements
Module: can_rx_frame

Interface
REQ-001 SHALL have port clk_i  input  1  single clock for all logic.
REQ-002 SHALL have port rst_n_i  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port rx_start_i  input  1  level enable; the block arms only while it is high.
REQ-004 SHALL have port bit_valid_i  input  1  one-cycle strobe per CAN bit sample point.
REQ-005 SHALL have port bit_i  input  1  sampled bus level, qualified by bit_valid_i; 0 = dominant.
REQ-006 SHALL have port rx_busy_o  output  1  high from SOF until the end of EOF or an error.
REQ-007 SHALL have port ack_o  output  1  bus drive request; 0 = dominant.
REQ-008 SHALL have port frame_valid_o  output  1  one-cycle pulse on a good frame.
REQ-009 SHALL have port message_type_o  output  1  ID bit 28.
REQ-010 SHALL have port local_address_o  output  6  ID bits 27:22.
REQ-011 SHALL have port remote_address_o  output  6  ID bits 21:16.
REQ-012 SHALL have port handshake_o  output  2  ID bits 15:14.
REQ-013 SHALL have port atribute_o  output  2  ID bits 13:12.
REQ-014 SHALL have port expand_count_o  output  4  ID bits 11:8.
REQ-015 SHALL have port cmd_data_sign_o  output  8  ID bits 7:0.
REQ-016 SHALL have port dlc_o  output  4  received DLC.
REQ-017 SHALL have port data_o  output  64  payload; first byte at [63:56]; unused bytes are 0.
REQ-018 SHALL have port crc_err_o, stuff_err_o and form_err_o  output  1 each  one-cycle error pulses.

Function
REQ-019 SHALL act only on cycles where bit_valid_i=1; all other cycles hold state.
REQ-020 SHALL use states IDLE, ARB1(11), SRR_IDE(2), ARB2(18), RTR_R1_R0(3), DLC(4), DATA(8*min(dlc,8)), CRC(15), CRC_DEL, ACK, ACK_DEL, EOF(7); bit counts are shown in brackets.
REQ-021 SHALL leave IDLE on a dominant bit with rx_start_i=1, treating that bit as SOF; rx_busy_o SHALL rise on the next clock.
REQ-022 SHALL destuff from SOF through the last CRC bit:
  - after 5 consecutive equal bits, the next bit is a stuff bit and is discarded;
  - if that stuff bit equals the previous bits, SHALL pulse stuff_err_o and go to IDLE.
REQ-023 SHALL assemble the 29-bit ID as ARB1 followed by ARB2, MSB first.
REQ-024 SHALL require SRR=1, IDE=1 and RTR=0; r1 and r0 are don't-care; any violation SHALL pulse form_err_o and go to IDLE.
REQ-025 SHALL treat a DLC value of 9-15 as 8 data bytes while reporting the raw DLC on dlc_o.
REQ-026 SHALL compute CRC-15 (polynomial 0x4599, init 0) over the destuffed bits from SOF through the last data bit.
REQ-027 SHALL compare the received CRC against the computed CRC; a mismatch SHALL pulse crc_err_o at CRC_DEL.
REQ-028 SHALL require CRC_DEL, ACK_DEL and all 7 EOF bits to be recessive; a violation SHALL pulse form_err_o and go to IDLE.
REQ-029 SHALL ignore the bus level sampled in the ACK slot.
REQ-030 SHALL update the field outputs and pulse frame_valid_o together, one clock after the 7th EOF bit, only if no error occurred; otherwise the outputs SHALL hold the previous frame.
REQ-031 SHALL return to IDLE and clear rx_busy_o on any error, and SHALL NOT pulse frame_valid_o.
REQ-032 SHALL finish the current frame if rx_start_i drops mid-frame, then stay in IDLE.
REQ-033 SHALL never assert more than one of frame_valid_o, crc_err_o, stuff_err_o and form_err_o for a given frame.

Reset
REQ-034 SHALL, while rst_n_i=0, immediately force state=IDLE, ack_o=1, all other outputs 0, and clear all counters and the CRC register.
REQ-035 SHALL discard any partial frame on reset mid-frame; the first frame after reset SHALL be received normally.

Configuration
REQ-036 SHALL, with CAN_RX_ACK_EN defined, drive ack_o=0 for exactly the ACK bit period when the CRC matched; ack_o is 1 at all other times.
REQ-037 SHALL, without CAN_RX_ACK_EN, tie ack_o to 1 and leave all other behaviour identical.

Verification
REQ-038 SHALL pass this case: send a frame with type=0, local=000101, remote=100010, handshake=10, atribute=10, expand=1011, cmd=F5, dlc=1001, data=3132333435363738 -> one frame_valid_o pulse, the same field values, and dlc_o=1001.
REQ-039 SHALL pass this case: the same frame with one CRC bit inverted -> crc_err_o pulses once, no frame_valid_o, and ack_o stays 1 with CAN_RX_ACK_EN defined.
REQ-040 SHALL pass this case: 6 consecutive dominant bits inside ARB1 -> stuff_err_o pulses on the 6th bit and rx_busy_o falls.
REQ-041 SHALL pass this case: a dominant bit at EOF bit 4 -> form_err_o pulses and the field outputs hold the previous frame.
REQ-042 SHALL pass this case: a good frame with dlc=0 -> data_o=0, then back-to-back a second good frame -> two frame_valid_o pulses.
REQ-043 SHALL pass this case: rst_n_i asserted in the DATA state -> outputs reset immediately, then the next frame decodes correctly.

Source files
------------

// File: rtl/can_rx_frame.sv
// CAN 2.0B extended-frame receiver: destuffing, CRC-15 check, form checks and ID/DLC/data decode.
// Define CAN_RX_ACK_EN to drive a dominant ACK bit when the received CRC matches.
module can_rx_frame (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        rx_start_i,
    input  logic        bit_valid_i,
    input  logic        bit_i,
    output logic        rx_busy_o,
    output logic        ack_o,
    output logic        frame_valid_o,
    output logic        message_type_o,
    output logic [5:0]  local_address_o,
    output logic [5:0]  remote_address_o,
    output logic [1:0]  handshake_o,
    output logic [1:0]  atribute_o,
    output logic [3:0]  expand_count_o,
    output logic [7:0]  cmd_data_sign_o,
    output logic [3:0]  dlc_o,
    output logic [63:0] data_o,
    output logic        crc_err_o,
    output logic        stuff_err_o,
    output logic        form_err_o
);
    typedef enum logic [3:0] {
        IDLE, ARB1, SRR_IDE, ARB2, RTR_R1_R0, DLC, DATA, CRC, CRC_DEL, ACK, ACK_DEL, EOF
    } state_t;

    state_t      state;
    logic [5:0]  cnt;
    logic [2:0]  run;
    logic        last_bit;
    logic [28:0] id_sr;
    logic [3:0]  dlc_sr;
    logic [63:0] data_sr;
    logic [14:0] crc_calc, crc_rx, crc_upd;
    logic [3:0]  nbytes;
    logic [6:0]  data_bits;
    logic        stuff_zone, stuff_bit, crc_ok;

    // CRC_DEL stays in the stuff zone so a stuff bit following the last CRC bit is still removed.
    always_comb begin
        nbytes     = (dlc_sr > 4'd8) ? 4'd8 : dlc_sr;
        data_bits  = {nbytes, 3'b000};
        stuff_zone = state inside {ARB1, SRR_IDE, ARB2, RTR_R1_R0, DLC, DATA, CRC, CRC_DEL};
        stuff_bit  = stuff_zone && (run == 3'd5);
        crc_ok     = (crc_rx == crc_calc);
        crc_upd    = {crc_calc[13:0], 1'b0} ^ ((bit_i ^ crc_calc[14]) ? 15'h4599 : 15'h0000);
    end

    assign rx_busy_o = (state != IDLE);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state            <= IDLE;
            cnt              <= '0;
            run              <= '0;
            last_bit         <= 1'b0;
            id_sr            <= '0;
            dlc_sr           <= '0;
            data_sr          <= '0;
            crc_calc         <= '0;
            crc_rx           <= '0;
            frame_valid_o    <= 1'b0;
            crc_err_o        <= 1'b0;
            stuff_err_o      <= 1'b0;
            form_err_o       <= 1'b0;
            message_type_o   <= 1'b0;
            local_address_o  <= '0;
            remote_address_o <= '0;
            handshake_o      <= '0;
            atribute_o       <= '0;
            expand_count_o   <= '0;
            cmd_data_sign_o  <= '0;
            dlc_o            <= '0;
            data_o           <= '0;
        end else begin
            frame_valid_o <= 1'b0;
            crc_err_o     <= 1'b0;
            stuff_err_o   <= 1'b0;
            form_err_o    <= 1'b0;
            if (bit_valid_i) begin
                if (stuff_bit) begin
                    if (bit_i == last_bit) begin
                        stuff_err_o <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        last_bit <= bit_i;
                        run      <= 3'd1;
                    end
                end else begin
                    if (stuff_zone) begin
                        last_bit <= bit_i;
                        run      <= (bit_i == last_bit) ? run + 3'd1 : 3'd1;
                    end
                    if (state inside {ARB1, SRR_IDE, ARB2, RTR_R1_R0, DLC, DATA})
                        crc_calc <= crc_upd;
                    cnt <= cnt + 6'd1;
                    case (state)
                        IDLE: begin
                            if (rx_start_i && !bit_i) begin
                                state    <= ARB1;
                                cnt      <= '0;
                                run      <= 3'd1;
                                last_bit <= 1'b0;
                                id_sr    <= '0;
                                dlc_sr   <= '0;
                                data_sr  <= '0;
                                crc_calc <= '0;
                                crc_rx   <= '0;
                            end
                        end
                        ARB1: begin
                            id_sr <= {id_sr[27:0], bit_i};
                            if (cnt == 6'd10) begin
                                state <= SRR_IDE;
                                cnt   <= '0;
                            end
                        end
                        SRR_IDE: begin
                            if (!bit_i) begin
                                form_err_o <= 1'b1;
                                state      <= IDLE;
                            end else if (cnt == 6'd1) begin
                                state <= ARB2;
                                cnt   <= '0;
                            end
                        end
                        ARB2: begin
                            id_sr <= {id_sr[27:0], bit_i};
                            if (cnt == 6'd17) begin
                                state <= RTR_R1_R0;
                                cnt   <= '0;
                            end
                        end
                        RTR_R1_R0: begin
                            if (cnt == 6'd0 && bit_i) begin
                                form_err_o <= 1'b1;
                                state      <= IDLE;
                            end else if (cnt == 6'd2) begin
                                state <= DLC;
                                cnt   <= '0;
                            end
                        end
                        DLC: begin
                            dlc_sr <= {dlc_sr[2:0], bit_i};
                            if (cnt == 6'd3) begin
                                state <= ({dlc_sr[2:0], bit_i} == 4'd0) ? CRC : DATA;
                                cnt   <= '0;
                            end
                        end
                        DATA: begin
                            data_sr[6'd63 - cnt] <= bit_i;
                            if ({1'b0, cnt} == data_bits - 7'd1) begin
                                state <= CRC;
                                cnt   <= '0;
                            end
                        end
                        CRC: begin
                            crc_rx <= {crc_rx[13:0], bit_i};
                            if (cnt == 6'd14) begin
                                state <= CRC_DEL;
                                cnt   <= '0;
                            end
                        end
                        CRC_DEL: begin
                            if (!crc_ok) begin
                                crc_err_o <= 1'b1;
                                state     <= IDLE;
                            end else if (!bit_i) begin
                                form_err_o <= 1'b1;
                                state      <= IDLE;
                            end else begin
                                state <= ACK;
                            end
                        end
                        ACK: state <= ACK_DEL;
                        ACK_DEL: begin
                            if (!bit_i) begin
                                form_err_o <= 1'b1;
                                state      <= IDLE;
                            end else begin
                                state <= EOF;
                                cnt   <= '0;
                            end
                        end
                        EOF: begin
                            if (!bit_i) begin
                                form_err_o <= 1'b1;
                                state      <= IDLE;
                            end else if (cnt == 6'd6) begin
                                state            <= IDLE;
                                frame_valid_o    <= 1'b1;
                                message_type_o   <= id_sr[28];
                                local_address_o  <= id_sr[27:22];
                                remote_address_o <= id_sr[21:16];
                                handshake_o      <= id_sr[15:14];
                                atribute_o       <= id_sr[13:12];
                                expand_count_o   <= id_sr[11:8];
                                cmd_data_sign_o  <= id_sr[7:0];
                                dlc_o            <= dlc_sr;
                                data_o           <= data_sr;
                            end
                        end
                        default: state <= IDLE;
                    endcase
                end
            end
        end
    end

`ifdef CAN_RX_ACK_EN
    // Dominant from the CRC_DEL sample until the ACK slot sample.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)
            ack_o <= 1'b1;
        else if (bit_valid_i)
            ack_o <= !(state == CRC_DEL && !stuff_bit && crc_ok && bit_i);
    end
`else
    assign ack_o = 1'b1;
`endif

endmodule

// File: tb/tb_can_rx_frame.sv
// Self-checking bench for can_rx_frame: frames are built from the bit-level CAN rules
// (long-division CRC, stuffing) and outcomes compared against expected pulses and fields.
module tb_can_rx_frame;
    logic        clk_i = 1'b0;
    logic        rst_n_i, rx_start_i, bit_valid_i, bit_i;
    logic        rx_busy_o, ack_o, frame_valid_o, message_type_o;
    logic [5:0]  local_address_o, remote_address_o;
    logic [1:0]  handshake_o, atribute_o;
    logic [3:0]  expand_count_o, dlc_o;
    logic [7:0]  cmd_data_sign_o;
    logic [63:0] data_o;
    logic        crc_err_o, stuff_err_o, form_err_o;

    can_rx_frame dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .rx_start_i(rx_start_i),
        .bit_valid_i(bit_valid_i), .bit_i(bit_i), .rx_busy_o(rx_busy_o), .ack_o(ack_o),
        .frame_valid_o(frame_valid_o), .message_type_o(message_type_o),
        .local_address_o(local_address_o), .remote_address_o(remote_address_o),
        .handshake_o(handshake_o), .atribute_o(atribute_o), .expand_count_o(expand_count_o),
        .cmd_data_sign_o(cmd_data_sign_o), .dlc_o(dlc_o), .data_o(data_o),
        .crc_err_o(crc_err_o), .stuff_err_o(stuff_err_o), .form_err_o(form_err_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0, errors = 0;
    int fv_cnt = 0, crc_cnt = 0, stuff_cnt = 0, form_cnt = 0, ack_low_cnt = 0;
    bit raw_q[$];
    bit tx_q[$];
    int tx_ack_idx, send_n;
    logic        ack_at_slot;
    logic [28:0] exp_id;
    logic [3:0]  exp_dlc;
    logic [63:0] exp_data;

    always @(negedge clk_i) begin
        if (rst_n_i) begin
            if (frame_valid_o) fv_cnt++;
            if (crc_err_o) crc_cnt++;
            if (stuff_err_o) stuff_cnt++;
            if (form_err_o) form_cnt++;
            if (!ack_o) ack_low_cnt++;
        end
    end

    function automatic logic [28:0] dut_id();
        return {message_type_o, local_address_o, remote_address_o, handshake_o,
                atribute_o, expand_count_o, cmd_data_sign_o};
    endfunction

    // Remainder of M(x)*x^15 divided by x^15+0x4599, by plain long division.
    function automatic logic [14:0] crc15();
        bit a[$];
        logic [15:0] g;
        logic [14:0] r;
        int n;
        g = 16'hC599;
        a = raw_q;
        n = raw_q.size();
        repeat (15) a.push_back(1'b0);
        for (int i = 0; i < n; i++)
            if (a[i]) for (int k = 0; k < 16; k++) a[i+k] = a[i+k] ^ g[15-k];
        for (int k = 0; k < 15; k++) r[14-k] = a[n+k];
        return r;
    endfunction

    // kind: 0 good, 1 CRC bit flipped, 2 SRR dominant, 3 RTR recessive,
    // 4 CRC_DEL dominant, 5 ACK_DEL dominant, 6 EOF bit (pos%7) dominant.
    task automatic build_frame(input logic [28:0] id, input logic [3:0] dlc,
                               input logic [63:0] data, input int kind, input int pos);
        logic [14:0] crc;
        int nb, run, err_raw;
        bit prev, b;
        bit full[$];
        raw_q.delete();
        tx_q.delete();
        raw_q.push_back(1'b0);
        for (int i = 28; i >= 18; i--) raw_q.push_back(id[i]);
        raw_q.push_back(kind == 2 ? 1'b0 : 1'b1);
        raw_q.push_back(1'b1);
        for (int i = 17; i >= 0; i--) raw_q.push_back(id[i]);
        raw_q.push_back(kind == 3 ? 1'b1 : 1'b0);
        raw_q.push_back(1'($urandom));
        raw_q.push_back(1'($urandom));
        for (int i = 3; i >= 0; i--) raw_q.push_back(dlc[i]);
        nb = (int'(dlc) > 8) ? 8 : int'(dlc);
        for (int i = 0; i < nb * 8; i++) raw_q.push_back(data[63-i]);
        crc = crc15();
        if (kind == 1) crc[pos % 15] = ~crc[pos % 15];
        full = raw_q;
        for (int i = 14; i >= 0; i--) full.push_back(crc[i]);
        err_raw = (kind == 2) ? 12 : (kind == 3) ? 32 : -1;
        send_n = -1;
        prev = 1'b0;
        run = 0;
        foreach (full[i]) begin
            b = full[i];
            tx_q.push_back(b);
            if (i == err_raw) send_n = tx_q.size();
            run = (i > 0 && b == prev) ? run + 1 : 1;
            prev = b;
            if (run == 5) begin
                tx_q.push_back(!b);
                prev = !b;
                run = 1;
            end
        end
        if (kind == 1 || kind == 4) send_n = tx_q.size() + 1;
        tx_q.push_back(kind == 4 ? 1'b0 : 1'b1);
        tx_ack_idx = tx_q.size();
        tx_q.push_back(1'($urandom));
        if (kind == 5) send_n = tx_q.size() + 1;
        tx_q.push_back(kind == 5 ? 1'b0 : 1'b1);
        for (int e = 0; e < 7; e++) begin
            if (kind == 6 && e == pos % 7) send_n = tx_q.size() + 1;
            tx_q.push_back((kind == 6 && e == pos % 7) ? 1'b0 : 1'b1);
        end
        if (send_n < 0) send_n = tx_q.size();
    endtask

    task automatic send_bits(input int n, input int drop_at);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_i); #1;
            if (i == drop_at) rx_start_i = 1'b0;
            bit_valid_i = 1'b1;
            bit_i = tx_q[i];
            if (i == tx_ack_idx) ack_at_slot = ack_o;
            @(posedge clk_i); #1;
            bit_valid_i = 1'b0;
            repeat ($urandom_range(0, 2)) @(posedge clk_i);
        end
    endtask

    // mode: 0 rx_start low, 1 rx_start high, 2 rx_start dropped after SOF.
    task automatic do_frame(input string name, input logic [28:0] id, input logic [3:0] dlc,
                            input logic [63:0] data, input int kind, input int pos, input int mode);
        int fv0, crc0, st0, fm0, al0, e_fv, e_crc, e_form, nb;
        bit armed, drive_ack;
        build_frame(id, dlc, data, kind, pos);
        armed = (mode != 0);
        rx_start_i = armed;
        fv0 = fv_cnt; crc0 = crc_cnt; st0 = stuff_cnt; fm0 = form_cnt; al0 = ack_low_cnt;
        ack_at_slot = 1'b1;
        send_bits(send_n, (mode == 2) ? 5 : -1);
        repeat (3) @(posedge clk_i);
        #1;
        rx_start_i = 1'b1;
        e_fv   = (armed && kind == 0) ? 1 : 0;
        e_crc  = (armed && kind == 1) ? 1 : 0;
        e_form = (armed && kind >= 2) ? 1 : 0;
`ifdef CAN_RX_ACK_EN
        drive_ack = armed && (kind == 0 || kind == 5 || kind == 6);
`else
        drive_ack = 1'b0;
`endif
        if (e_fv == 1) begin
            nb = (int'(dlc) > 8) ? 8 : int'(dlc);
            exp_id = id;
            exp_dlc = dlc;
            exp_data = '0;
            for (int i = 0; i < nb * 8; i++) exp_data[63-i] = data[63-i];
        end
        checks += 9;
        if ((fv_cnt - fv0) !== e_fv) begin errors++; $display("FAIL %s frame_valid pulses got %0d exp %0d", name, fv_cnt - fv0, e_fv); end
        if ((crc_cnt - crc0) !== e_crc) begin errors++; $display("FAIL %s crc_err pulses got %0d exp %0d", name, crc_cnt - crc0, e_crc); end
        if ((form_cnt - fm0) !== e_form) begin errors++; $display("FAIL %s form_err pulses got %0d exp %0d", name, form_cnt - fm0, e_form); end
        if ((stuff_cnt - st0) !== 0) begin errors++; $display("FAIL %s stuff_err pulses got %0d exp 0", name, stuff_cnt - st0); end
        if (rx_busy_o !== 1'b0) begin errors++; $display("FAIL %s rx_busy got %b exp 0", name, rx_busy_o); end
        if (dut_id() !== exp_id) begin errors++; $display("FAIL %s id got %h exp %h", name, dut_id(), exp_id); end
        if (dlc_o !== exp_dlc) begin errors++; $display("FAIL %s dlc got %h exp %h", name, dlc_o, exp_dlc); end
        if (data_o !== exp_data) begin errors++; $display("FAIL %s data got %h exp %h", name, data_o, exp_data); end
        if (drive_ack) begin
            if (ack_at_slot !== 1'b0) begin errors++; $display("FAIL %s ack_slot got %b exp 0", name, ack_at_slot); end
        end else if ((ack_low_cnt - al0) !== 0) begin
            errors++; $display("FAIL %s ack_low_cycles got %0d exp 0", name, ack_low_cnt - al0);
        end
    endtask

    task automatic test_reset();
        rst_n_i = 1'b0; rx_start_i = 1'b1; bit_valid_i = 1'b0; bit_i = 1'b1;
        #12;
        exp_id = '0; exp_dlc = '0; exp_data = '0;
        checks += 5;
        if (rx_busy_o !== 1'b0) begin errors++; $display("FAIL reset rx_busy got %b exp 0", rx_busy_o); end
        if (ack_o !== 1'b1) begin errors++; $display("FAIL reset ack got %b exp 1", ack_o); end
        if ({frame_valid_o, crc_err_o, stuff_err_o, form_err_o} !== 4'b0) begin
            errors++; $display("FAIL reset pulses got %b exp 0000", {frame_valid_o, crc_err_o, stuff_err_o, form_err_o});
        end
        if (dut_id() !== 29'd0 || dlc_o !== 4'd0) begin errors++; $display("FAIL reset id/dlc got %h/%h exp 0/0", dut_id(), dlc_o); end
        if (data_o !== 64'd0) begin errors++; $display("FAIL reset data got %h exp 0", data_o); end
        @(negedge clk_i);
        rst_n_i = 1'b1;
    endtask

    localparam logic [28:0] REF_ID = {1'b0, 6'b000101, 6'b100010, 2'b10, 2'b10, 4'b1011, 8'hF5};

    task automatic test_reference_frame();
        do_frame("ref_frame", REF_ID, 4'b1001, 64'h3132333435363738, 0, 0, 1);
        checks += 3;
        if (local_address_o !== 6'b000101) begin errors++; $display("FAIL ref_local got %b exp 000101", local_address_o); end
        if (remote_address_o !== 6'b100010 || handshake_o !== 2'b10 || atribute_o !== 2'b10) begin
            errors++; $display("FAIL ref_fields got %b %b %b exp 100010 10 10", remote_address_o, handshake_o, atribute_o);
        end
        if (expand_count_o !== 4'b1011 || cmd_data_sign_o !== 8'hF5 || message_type_o !== 1'b0) begin
            errors++; $display("FAIL ref_cmd got %b %h %b exp 1011 f5 0", expand_count_o, cmd_data_sign_o, message_type_o);
        end
    endtask

    task automatic test_crc_error();
        do_frame("crc_flip", REF_ID, 4'b1001, 64'h3132333435363738, 1, 7, 1);
    endtask

    task automatic test_stuff_error();
        int st0;
        st0 = stuff_cnt;
        rx_start_i = 1'b1;
        tx_q = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tx_ack_idx = -1;
        send_bits(7, -1);
        checks += 4;
        if (stuff_cnt !== st0 || rx_busy_o !== 1'b1) begin
            errors++; $display("FAIL stuff_pre pulses/busy got %0d/%b exp 0/1", stuff_cnt - st0, rx_busy_o);
        end
        tx_q = '{1'b0};
        send_bits(1, -1);
        if (stuff_cnt - st0 !== 1) begin errors++; $display("FAIL stuff_err pulses got %0d exp 1", stuff_cnt - st0); end
        if (rx_busy_o !== 1'b0) begin errors++; $display("FAIL stuff_busy got %b exp 0", rx_busy_o); end
        if (dut_id() !== exp_id) begin errors++; $display("FAIL stuff_hold id got %h exp %h", dut_id(), exp_id); end
    endtask

    task automatic test_eof_form();
        do_frame("pre_eof", 29'($urandom), 4'($urandom_range(1, 8)), {$urandom, $urandom}, 0, 0, 1);
        do_frame("eof_bit4", 29'($urandom), 4'd5, {$urandom, $urandom}, 6, 3, 1);
    endtask

    task automatic test_back_to_back();
        int fv0;
        fv0 = fv_cnt;
        do_frame("b2b_dlc0", 29'($urandom), 4'd0, {$urandom, $urandom}, 0, 0, 1);
        do_frame("b2b_second", 29'($urandom), 4'($urandom_range(1, 15)), {$urandom, $urandom}, 0, 0, 1);
        checks++;
        if (fv_cnt - fv0 !== 2) begin errors++; $display("FAIL b2b pulses got %0d exp 2", fv_cnt - fv0); end
    endtask

    task automatic test_reset_mid_frame();
        build_frame(29'($urandom), 4'd8, {$urandom, $urandom}, 0, 0);
        rx_start_i = 1'b1;
        send_bits(55, -1);
        @(posedge clk_i); #3;
        rst_n_i = 1'b0;
        #1;
        exp_id = '0; exp_dlc = '0; exp_data = '0;
        checks += 3;
        if (rx_busy_o !== 1'b0 || ack_o !== 1'b1) begin
            errors++; $display("FAIL midrst busy/ack got %b/%b exp 0/1", rx_busy_o, ack_o);
        end
        if (dut_id() !== 29'd0 || dlc_o !== 4'd0) begin errors++; $display("FAIL midrst id/dlc got %h/%h exp 0/0", dut_id(), dlc_o); end
        if (data_o !== 64'd0) begin errors++; $display("FAIL midrst data got %h exp 0", data_o); end
        @(negedge clk_i);
        rst_n_i = 1'b1;
        do_frame("after_rst", 29'($urandom), 4'($urandom_range(0, 15)), {$urandom, $urandom}, 0, 0, 1);
    endtask

    task automatic test_random();
        int kind, mode, m;
        for (int n = 0; n < 24; n++) begin
            kind = $urandom_range(0, 10);
            if (kind > 6) kind = 0;
            m = $urandom_range(0, 5);
            mode = (m == 0) ? 0 : (m == 1) ? 2 : 1;
            do_frame($sformatf("rand%0d", n), 29'($urandom), 4'($urandom_range(0, 15)),
                     {$urandom, $urandom}, kind, $urandom_range(0, 30), mode);
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_reference_frame();
        test_crc_error();
        test_stuff_error();
        test_eof_form();
        test_back_to_back();
        test_reset_mid_frame();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
